vedic_mul_seq_ctrl: RTL and testbench

VEDIC_MUL_SEQ_CTRL -- requirements
Module: vedic_mul_seq_ctrl

---
 rtl/vedic_mul_seq_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_vedic_mul_seq_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_mul_seq_ctrl.sv
// vedic_mul_seq_ctrl
// Sequential unsigned multiplier that builds a W x W product from one
// 2x2 Vedic (Urdhva-Tiryagbhyam) cell, one 2-bit digit pair per cycle.
// Digit pairs are walked with j as the inner index and i as the outer
// index. Each partial product is shifted into place and summed into a
// 2W-bit accumulator. The finished product is held on p until the
// consumer takes it.
//
// Optional feature macro: VEDIC_ZERO_SKIP_EN
//   When defined, an operand pair with a zero operand goes directly from
//   IDLE to DONE on the accepting edge with p = 0, and RUN is skipped.
//   When undefined, zero operands take the normal N*N-cycle path.

// 2-bit x 2-bit Vedic product cell: vertical and crosswise terms, two half adds
module vedic_mul_2x2 (
  input  logic [1:0] i_x,
  input  logic [1:0] i_y,
  output logic [3:0] o_p
);

  logic w_vert0;
  logic w_cross0;
  logic w_cross1;
  logic w_vert1;
  logic w_carry1;

  assign w_vert0  = i_x[0] & i_y[0];
  assign w_cross0 = i_x[1] & i_y[0];
  assign w_cross1 = i_x[0] & i_y[1];
  assign w_vert1  = i_x[1] & i_y[1];
  assign w_carry1 = w_cross0 & w_cross1;

  assign o_p[0] = w_vert0;
  assign o_p[1] = w_cross0 ^ w_cross1;
  assign o_p[2] = w_vert1 ^ w_carry1;
  assign o_p[3] = w_vert1 & w_carry1;

endmodule

module vedic_mul_seq_ctrl #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  // Digit count, index width, product width and shift-amount width
  localparam int N  = W / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * W;
  localparam int SW = IW + 2;

  localparam logic [IW-1:0] LAST_DIGIT = IW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // Captured operands. They are sampled only at acceptance, so the input
  // pins may change freely while RUN is in progress.
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [PW-1:0] r_acc;
  logic [PW-1:0] r_p;
  logic [IW-1:0] r_i;
  logic [IW-1:0] r_j;

  logic [1:0]    w_aDigit;
  logic [1:0]    w_bDigit;
  logic [3:0]    w_cellProd;
  logic [SW-1:0] w_shift;
  logic [PW-1:0] w_term;
  logic [PW-1:0] w_sum;
  logic          w_lastDigit;
  logic          w_lastInner;
  logic          w_zeroOp;

`ifdef VEDIC_ZERO_SKIP_EN
  assign w_zeroOp = (a == '0) || (b == '0);
`else
  assign w_zeroOp = 1'b0;
`endif

  assign w_aDigit    = r_a[{r_i, 1'b0} +: 2];
  assign w_bDigit    = r_b[{r_j, 1'b0} +: 2];
  assign w_lastInner = (r_j == LAST_DIGIT);
  assign w_lastDigit = (r_i == LAST_DIGIT) && w_lastInner;

  vedic_mul_2x2 u_cell (
    .i_x (w_aDigit),
    .i_y (w_bDigit),
    .o_p (w_cellProd)
  );

  // Digit pair (i,j) has weight 4^(i+j), so the shift is 2*i + 2*j bits
  assign w_shift = {1'b0, r_i, 1'b0} + {1'b0, r_j, 1'b0};
  assign w_term  = PW'(w_cellProd) << w_shift;
  assign w_sum   = r_acc + w_term;

  assign p = r_p;

  // State register; reset abandons any operation that is in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and handshake/status outputs decoded from the state
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_nextState = w_zeroOp ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_lastDigit) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Operand capture, digit walk, accumulation and result publish
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_p   <= '0;
      r_i   <= '0;
      r_j   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_i   <= '0;
            r_j   <= '0;
            if (w_zeroOp) begin
              r_p <= '0;
            end
          end
        end
        ST_RUN: begin
          r_acc <= w_sum;
          if (w_lastDigit) begin
            r_p <= w_sum;
            r_i <= '0;
            r_j <= '0;
          end else if (w_lastInner) begin
            r_j <= '0;
            r_i <= r_i + IW'(1);
          end else begin
            r_j <= r_j + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_mul_seq_ctrl.sv
// tb_vedic_mul_seq_ctrl
// Directed bench for vedic_mul_seq_ctrl at W=8. The stimulus pushes the
// expected product for each accepted pair into a queue. A monitor pops
// and compares the queue on every output handshake. Timing, status and
// hold checks are made inline by the stimulus process.

module tb_vedic_mul_seq_ctrl;

  localparam int W  = 8;
  localparam int N  = W / 2;
  localparam int RUN_CYCLES = N * N;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;
  logic           busy;

  logic [2*W-1:0] expQ[$];
  int             testsRun  = 0;
  int             failCount = 0;
  int             cycleCount = 0;

  vedic_mul_seq_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used for throughput spacing
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Hard time limit so the run can never hang
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    testsRun++;
    if (act !== req) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Wait at negedges for in_ready, present the pair, hold it across the accepting edge
  task automatic applyStimulus(input logic [W-1:0] aIn, input logic [W-1:0] bIn,
                               input bit doPush, input logic [2*W-1:0] expP);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      testsRun++;
      failCount++;
      $display("[TB] FAIL acceptTimeout: in_ready=0, required 1");
    end
    a = aIn;
    b = bIn;
    in_valid = 1'b1;
    if (doPush) expQ.push_back(expP);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count edges after the accepting edge until out_valid is seen, noting any busy
  task automatic waitOutValid(output int edges, output bit busySeen);
    edges = 0;
    busySeen = 1'b0;
    @(negedge clk);
    if (busy) busySeen = 1'b1;
    while (!out_valid && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (busy) busySeen = 1'b1;
    end
  endtask

  // Scoreboard monitor: every output handshake consumes one expected product
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        testsRun++;
        failCount++;
        $display("[TB] FAIL unexpectedOutput: p=%0h presented, required no output", p);
      end else begin
        checkOutput("product", 32'(p), 32'(expQ.pop_front()));
      end
    end
  end

  initial begin
    int  edges;
    bit  busySeen;
    int  outCount;
    int  lastAcc;
    int  accepted;
    int  guard;
    bit  prevZero;
    int  spacing;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstInReady", 32'(in_ready), 32'd1);
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstP", 32'(p), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // All-ones operands, full latency, single-cycle out_valid
    applyStimulus(8'hFF, 8'hFF, 1'b1, 16'hFE01);
    waitOutValid(edges, busySeen);
    checkOutput("ffLatency", 32'(edges), 32'(RUN_CYCLES));
    checkOutput("ffBusySeen", 32'(busySeen), 32'd1);
    checkOutput("ffP", 32'(p), 32'h0000FE01);
    @(posedge clk);
    @(negedge clk);
    checkOutput("ffOneCycle", 32'(out_valid), 32'd0);
    checkOutput("ffBackIdle", 32'(in_ready), 32'd1);

    // Back-pressure: result held while out_ready is low
    @(posedge clk);
    #1 out_ready = 1'b0;
    applyStimulus(8'd13, 8'd11, 1'b1, 16'd143);
    waitOutValid(edges, busySeen);
    checkOutput("holdLatency", 32'(edges), 32'(RUN_CYCLES));
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      checkOutput("holdValid", 32'(out_valid), 32'd1);
      checkOutput("holdP", 32'(p), 32'd143);
      checkOutput("holdInReady", 32'(in_ready), 32'd0);
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("holdIdleReady", 32'(in_ready), 32'd1);
    checkOutput("holdIdleValid", 32'(out_valid), 32'd0);
    checkOutput("holdIdleP", 32'(p), 32'd143);

    // Zero multiplicand
    applyStimulus(8'h00, 8'h5A, 1'b1, 16'h0000);
    waitOutValid(edges, busySeen);
`ifdef VEDIC_ZERO_SKIP_EN
    checkOutput("zeroLatency", 32'(edges), 32'd0);
    checkOutput("zeroBusySeen", 32'(busySeen), 32'd0);
`else
    checkOutput("zeroLatency", 32'(edges), 32'(RUN_CYCLES));
    checkOutput("zeroBusySeen", 32'(busySeen), 32'd1);
`endif
    checkOutput("zeroP", 32'(p), 32'd0);

    // Reset in the middle of RUN aborts the pair; in_valid during reset ignored
    applyStimulus(8'hA5, 8'h3C, 1'b0, 16'h0000);
    repeat (6) @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 8'hFF;
    b        = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abortInReady", 32'(in_ready), 32'd1);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortOutValid", 32'(out_valid), 32'd0);
    checkOutput("abortP", 32'(p), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstIgnoreInValid", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    outCount = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) outCount++;
    end
    checkOutput("abortNoOutput", 32'(outCount), 32'd0);
    applyStimulus(8'h02, 8'h03, 1'b1, 16'h0006);
    waitOutValid(edges, busySeen);
    checkOutput("postAbortLatency", 32'(edges), 32'(RUN_CYCLES));
    checkOutput("postAbortP", 32'(p), 32'h0006);

    // in_valid and operand changes during RUN are ignored; p retained in RUN
    applyStimulus(8'h10, 8'h10, 1'b1, 16'h0100);
    @(negedge clk);
    checkOutput("runRetainP", 32'(p), 32'h0006);
    checkOutput("runBusy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a        = 8'hFF;
    b        = 8'hFF;
    repeat (5) @(posedge clk);
    #1 in_valid = 1'b0;
    waitOutValid(edges, busySeen);
    checkOutput("ignoreP", 32'(p), 32'h0100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("ignoreIdle", 32'(in_ready), 32'd1);

    // Back-to-back random pairs with in_valid held high
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = W'($urandom_range(0, 255));
    b         = W'($urandom_range(0, 255));
    lastAcc   = -1;
    accepted  = 0;
    guard     = 0;
    prevZero  = 1'b0;
    while (accepted < 1000 && guard < 40000) begin
      @(negedge clk);
      guard++;
      if (in_ready) begin
        expQ.push_back((2*W)'(a) * (2*W)'(b));
        if (lastAcc >= 0) begin
`ifdef VEDIC_ZERO_SKIP_EN
          spacing = prevZero ? 2 : RUN_CYCLES + 2;
`else
          spacing = RUN_CYCLES + 2;
`endif
          checkOutput("b2bSpacing", 32'(cycleCount - lastAcc), 32'(spacing));
        end
        prevZero = (a == '0) || (b == '0);
        lastAcc  = cycleCount;
        accepted++;
        @(posedge clk);
        #1;
        a = W'($urandom_range(0, 255));
        b = W'($urandom_range(0, 255));
      end
    end
    in_valid = 1'b0;
    checkOutput("b2bAccepted", 32'(accepted), 32'd1000);

    repeat (40) @(posedge clk);
    @(negedge clk);
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
